// File: rtl/alu_rr_arbiter.sv
// Round-robin front end sharing one external combinational ALU between N requesters.
// Define ALU_RR_ARBITER_OPCHK_EN to add rsp_err and force rsp_data=0 for opcodes above 9.
module alu_rr_arbiter #(
  parameter int N   = 2,
  parameter int IDW = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req_valid,
  output logic [N-1:0]    req_ready,
  input  logic [N*32-1:0] req_a,
  input  logic [N*32-1:0] req_b,
  input  logic [N*4-1:0]  req_op,
  output logic [31:0]     alu_a,
  output logic [31:0]     alu_b,
  output logic [3:0]      alu_ctrl,
  input  logic [31:0]     alu_out,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [31:0]     rsp_data,
  output logic [IDW-1:0]  rsp_id
`ifdef ALU_RR_ARBITER_OPCHK_EN
  ,
  output logic            rsp_err
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]     state_r;
  logic [IDW-1:0] last_grant_r;
  logic [IDW-1:0] gid_r;
  logic [31:0]    a_r;
  logic [31:0]    b_r;
  logic [3:0]     op_r;

  logic [IDW-1:0] grant_s;
  logic           found_s;
  logic [31:0]    sel_a_s;
  logic [31:0]    sel_b_s;
  logic [3:0]     sel_op_s;

  // Round-robin pick: smallest distance from last_grant+1 (mod N) among valid requesters.
  always_comb begin : arb_p
    int   dist_v;
    int   best_v;
    logic take_v;
    grant_s  = '0;
    found_s  = 1'b0;
    sel_a_s  = 32'd0;
    sel_b_s  = 32'd0;
    sel_op_s = 4'd0;
    dist_v   = 0;
    best_v   = N;
    take_v   = 1'b0;
    for (int i = 0; i < N; i++) begin
      dist_v  = (i + N - 1 - int'(last_grant_r)) % N;
      take_v  = req_valid[i] && (dist_v < best_v);
      best_v  = take_v ? dist_v : best_v;
      grant_s = take_v ? IDW'(i) : grant_s;
      found_s = found_s | req_valid[i];
    end
    for (int i = 0; i < N; i++) begin
      sel_a_s  = (grant_s == IDW'(i)) ? req_a[32*i +: 32] : sel_a_s;
      sel_b_s  = (grant_s == IDW'(i)) ? req_b[32*i +: 32] : sel_b_s;
      sel_op_s = (grant_s == IDW'(i)) ? req_op[4*i +: 4]  : sel_op_s;
    end
  end

  // Accept is combinational in IDLE and held low while reset is asserted.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N; i++) begin
      req_ready[i] = rst_n && (state_r == IDLE) && found_s && (grant_s == IDW'(i));
    end
  end

  assign alu_a    = a_r;
  assign alu_b    = b_r;
  assign alu_ctrl = op_r;

  // Control FSM, operand latch and registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      last_grant_r <= IDW'(N - 1);
      gid_r        <= '0;
      a_r          <= 32'd0;
      b_r          <= 32'd0;
      op_r         <= 4'd0;
      rsp_valid    <= 1'b0;
      rsp_data     <= 32'd0;
      rsp_id       <= '0;
`ifdef ALU_RR_ARBITER_OPCHK_EN
      rsp_err      <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (found_s) begin
            a_r          <= sel_a_s;
            b_r          <= sel_b_s;
            op_r         <= sel_op_s;
            gid_r        <= grant_s;
            last_grant_r <= grant_s;
            state_r      <= EXEC;
          end else begin
            state_r <= IDLE;
          end
        end
        EXEC: begin
`ifdef ALU_RR_ARBITER_OPCHK_EN
          rsp_err  <= (op_r > 4'd9);
          rsp_data <= (op_r > 4'd9) ? 32'd0 : alu_out;
`else
          rsp_data <= alu_out;
`endif
          rsp_id    <= gid_r;
          rsp_valid <= 1'b1;
          state_r   <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_r   <= IDLE;
          end else begin
            state_r <= RESP;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule
